scan_mux_n: RTL and testbench
=============================

Name: scan_mux_n

Overview:
Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage.
Manual mode: a loadable select register picks the channel.
Scan mode: a channel counter sweeps all inputs round-robin, one beat per accepted output.
Feeds downstream sampling/serialising logic that must see one tagged channel sample per beat.

Parameters:
WIDTH, 1, data bits per channel (>=1)
NCH, 4, number of input channels (power of two, >=2)
SELW, $clog2(NCH), localparam, select/tag width (not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
d  input  NCH*WIDTH  flattened channel inputs; channel k = d[k*WIDTH +: WIDTH]
en  input  1  enable; 0 = no new captures
mode  input  1  0 = manual, 1 = scan
load  input  1  write s_in into select register
s_in  input  SELW  select value for load
hold  input  1  scan mode: freeze channel counter
y  output  WIDTH  registered selected data
y_ch  output  SELW  channel index of current y
y_valid  output  1  y/y_ch hold a beat
y_ready  input  1  downstream accepts beat
wrap  output  1  one-cycle pulse, registered with the beat of channel NCH-1 in scan mode

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values: state IDLE, sel 0, y 0, y_ch 0, y_valid 0, wrap 0.
- rst overrides every other input, including load. A pending beat is dropped.
- FSM states: IDLE (en=0), MANUAL (en=1, mode=0), SCAN (en=1, mode=1).
  - Next state is derived from en/mode sampled each cycle; any state can go to any other.
  - Captures in a cycle use the current registered state.
- slot_free = !y_valid || y_ready.
- MANUAL or SCAN with slot_free, on the clock edge:
  - y <= d[sel], y_ch <= sel, y_valid <= 1.
  - Latency: d/sel to y is 1 cycle.
  - load to y is 2 cycles: the sel update, then the capture.
- IDLE, or no slot_free: y and y_ch hold their values.
  - In IDLE with y_valid && y_ready: y_valid <= 0.
- Stall: while y_valid && !y_ready, y, y_ch, y_valid and wrap are stable.
- Select register update, by priority:
  - load: sel <= s_in (any state, including IDLE).
  - Else SCAN && capture && !hold: sel <= sel+1, wrapping NCH-1 to 0.
  - Else hold sel.
- A capture in the same cycle as a load uses the old sel.
- wrap <= (state==SCAN && capture && sel==NCH-1). wrap clears when that beat is accepted, or when the next non-NCH-1 beat is captured. wrap follows the same stall rule as y.
- Entering SCAN keeps the current sel; the sweep starts from there.
- Mode switch mid-sweep leaves sel untouched.
- hold=1 in SCAN repeats the same channel on every capture.

Optional Feature:
SCAN_MUX_PARITY_EN
- Defined: adds output y_par (1 bit) = ^d[sel], registered alongside y under identical capture/stall/reset rules (reset 0).
- Undefined: y_par port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package scan_mux_pkg holds:
  - state_t enum {IDLE, MANUAL, SCAN}.
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1 constants.
- One sub-module: mux_n_comb, a purely combinational NCH:1 WIDTH-bit selector (d, sel -> out).
- The top instantiates mux_n_comb once, for y. It instantiates it a second time, on the parity vector, when SCAN_MUX_PARITY_EN is defined.

Test Plan:
1. Reset: rst=1 for 2 cycles with d all ones, en=1 -> y=0, y_ch=0, y_valid=0, wrap=0 on both cycles. First capture happens only once a full cycle in MANUAL/SCAN has elapsed after rst drops.
2. Exhaustive manual, NCH=4, WIDTH=1: en=1, mode=0, y_ready=1; for n=0..63, {s_in, d}=n with load=1, each held for 3 cycles -> y == d[s_in] and y_ch == s_in by cycle 2, for all 64 combinations.
3. Scan, WIDTH=8, d={8'h44,8'h33,8'h22,8'h11}, y_ready=1 -> y: 11,22,33,44,11; y_ch: 0,1,2,3,0; wrap=1 only with the 44 beat.
4. Backpressure: in scan, drop y_ready for 3 cycles while y=22 -> y=22, y_ch=1, y_valid=1 stable and sel=2 throughout. On ready=1, the next beat is 33.
5. Hold/load: scan with hold=1 -> y repeats 22. Then load s_in=3 in the same cycle as a capture -> that beat uses old sel; the following beats are 44 (wrap=1), then 11.
6. Reset mid-stall: y_valid=1, y_ready=0, sel=2, then rst=1 for one cycle -> next cycle y_valid=0, sel=0, y=0, state IDLE.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux_n block.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational NCH:1 selector of WIDTH-bit slices from a flattened bus.
module mux_n_comb #(
    parameter  int WIDTH = 1,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) out = d[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/scan_mux_n.sv
// N-channel registered mux with manual/scan select and a valid/ready output stage.
// Optional SCAN_MUX_PARITY_EN adds y_par, the registered parity of the selected channel.
module scan_mux_n
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 load,
    input  logic [SELW-1:0]      s_in,
    input  logic                 hold,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 y_valid,
    input  logic                 y_ready,
`ifdef SCAN_MUX_PARITY_EN
    output logic                 y_par,
`endif
    output logic                 wrap
);

    state_t           state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] y_q, mux_y;
    logic [SELW-1:0]  y_ch_q;
    logic             y_valid_q, wrap_q;
    logic             slot_free, capture;

    assign slot_free = !y_valid_q || y_ready;
    // Capture decision uses the registered state, not the one being entered.
    assign capture   = (state_q != IDLE) && slot_free;

    always_comb begin
        state_d = IDLE;
        if (en) state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
    end

    always_comb begin
        sel_d = sel_q;
        if (load)
            sel_d = s_in;
        else if (state_q == SCAN && capture && !hold)
            sel_d = SELW'(sel_q + 1'b1);
    end

    mux_n_comb #(.WIDTH(WIDTH), .NCH(NCH)) u_mux_y (
        .d   (d),
        .sel (sel_q),
        .out (mux_y)
    );

`ifdef SCAN_MUX_PARITY_EN
    logic [NCH-1:0] par_vec;
    logic           mux_par, par_q;

    for (genvar k = 0; k < NCH; k++) begin : g_par
        assign par_vec[k] = ^d[k*WIDTH +: WIDTH];
    end

    mux_n_comb #(.WIDTH(1), .NCH(NCH)) u_mux_par (
        .d   (par_vec),
        .sel (sel_q),
        .out (mux_par)
    );

    always_ff @(posedge clk) begin
        if (rst)          par_q <= 1'b0;
        else if (capture) par_q <= mux_par;
    end

    assign y_par = par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (capture) begin
                y_q       <= mux_y;
                y_ch_q    <= sel_q;
                y_valid_q <= 1'b1;
                wrap_q    <= (state_q == SCAN) && (sel_q == SELW'(NCH-1));
            end else if (y_valid_q && y_ready) begin
                // Only reachable in IDLE: the beat drains with nothing behind it.
                y_valid_q <= 1'b0;
                wrap_q    <= 1'b0;
            end
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Self-checking bench for scan_mux_n: vector table for manual mode, scoreboard for scan beats.
module tb_scan_mux_n;
    import scan_mux_pkg::*;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst, en, mode, load, hold, y_ready;
    logic [N*W-1:0] d;
    logic [SW-1:0] s_in;
    logic [W-1:0]  y;
    logic [SW-1:0] y_ch;
    logic          y_valid, wrap;

    always #5 clk = ~clk;

    scan_mux_n #(.WIDTH(W), .NCH(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .en      (en),
        .mode    (mode),
        .load    (load),
        .s_in    (s_in),
        .hold    (hold),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .wrap    (wrap)
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] bits;
        logic [7:0] ey;
        logic [1:0] ech;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic [1:0] ch;
        logic       wrap;
    } beat_t;

    vec_t  tbl [64];
    beat_t sbq [$];
    int    checks = 0;
    int    errors = 0;
    logic  sb_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] ey, input logic [1:0] ech, input logic ew);
        beat_t b;
        b.y = ey; b.ch = ech; b.wrap = ew;
        sbq.push_back(b);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic [1:0] ech,
                           input logic ev, input logic ew);
        chk({tag, "_y"},     32'(y),       32'(ey));
        chk({tag, "_ych"},   32'(y_ch),    32'(ech));
        chk({tag, "_valid"}, 32'(y_valid), 32'(ev));
        chk({tag, "_wrap"},  32'(wrap),    32'(ew));
    endtask

    // A beat is consumed at the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (sb_on && y_valid && y_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_beat", 32'(y), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("sb_y",    32'(y),    32'(e.y));
                chk("sb_ych",  32'(y_ch), 32'(e.ch));
                chk("sb_wrap", 32'(wrap), 32'(e.wrap));
            end
        end
    end

    function automatic logic [N*W-1:0] spread(input logic [3:0] b);
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W] = b[k];
        return r;
    endfunction

    initial begin
        for (int n = 0; n < 64; n++) begin
            logic [5:0] nv;
            nv          = 6'(n);
            tbl[n].s    = nv[5:4];
            tbl[n].bits = nv[3:0];
            tbl[n].ey   = {7'b0, nv[nv[5:4]]};
            tbl[n].ech  = nv[5:4];
        end

        // Reset with all-ones data and enable asserted.
        rst = 1'b1; en = 1'b1; mode = MODE_MANUAL; load = 1'b1; s_in = 2'd3;
        hold = 1'b0; y_ready = 1'b1; d = '1;
        tick(); chk_out("rst1", 8'h00, 2'd0, 1'b0, 1'b0);
        tick(); chk_out("rst2", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("rst_sel", 32'(dut.sel_q), 32'd0);
        rst = 1'b0; load = 1'b0;
        tick(); chk("first_edge_no_capture", 32'(y_valid), 32'd0);
        tick(); chk_out("first_capture", 8'hFF, 2'd0, 1'b1, 1'b0);

        // Exhaustive manual selection with load, each vector held three cycles.
        load = 1'b1;
        for (int n = 0; n < 64; n++) begin
            s_in = tbl[n].s;
            d    = spread(tbl[n].bits);
            tick(); tick();
            chk("man_y",   32'(y),    32'(tbl[n].ey));
            chk("man_ych", 32'(y_ch), 32'(tbl[n].ech));
            tick();
        end

        // Drain through IDLE and reset the sweep start to channel 0.
        en = 1'b0; s_in = 2'd0; d = {8'h44, 8'h33, 8'h22, 8'h11};
        tick(); tick();
        chk("idle_drain_valid", 32'(y_valid), 32'd0);
        load = 1'b0;
        sb_on = 1'b1;

        // Scan sweep 11,22,33,44,11,22 then backpressure on the 22 beat.
        push(8'h11, 2'd0, 1'b0); push(8'h22, 2'd1, 1'b0); push(8'h33, 2'd2, 1'b0);
        push(8'h44, 2'd3, 1'b1); push(8'h11, 2'd0, 1'b0); push(8'h22, 2'd1, 1'b0);
        en = 1'b1; mode = MODE_SCAN;
        tick();
        chk("scan_entry_no_capture", 32'(y_valid), 32'd0);
        repeat (6) tick();
        chk_out("bp_start", 8'h22, 2'd1, 1'b1, 1'b0);
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_stall", 8'h22, 2'd1, 1'b1, 1'b0);
            chk("bp_sel", 32'(dut.sel_q), 32'd2);
        end
        y_ready = 1'b1;
        push(8'h33, 2'd2, 1'b0);
        tick();
        chk_out("bp_resume", 8'h33, 2'd2, 1'b1, 1'b0);

        // Hold repeats channel 1; a load in the same cycle as a capture uses the old sel.
        push(8'h44, 2'd3, 1'b1);
        hold = 1'b1; load = 1'b1; s_in = 2'd1;
        tick();
        load = 1'b0;
        push(8'h22, 2'd1, 1'b0); push(8'h22, 2'd1, 1'b0); push(8'h22, 2'd1, 1'b0);
        tick(); tick(); tick();
        chk("hold_sel", 32'(dut.sel_q), 32'd1);
        push(8'h22, 2'd1, 1'b0);
        hold = 1'b0; load = 1'b1; s_in = 2'd3;
        tick();
        chk_out("load_old_sel", 8'h22, 2'd1, 1'b1, 1'b0);
        load = 1'b0;
        push(8'h44, 2'd3, 1'b1);
        tick();
        chk_out("after_load", 8'h44, 2'd3, 1'b1, 1'b1);
        tick();
        chk_out("after_wrap", 8'h11, 2'd0, 1'b1, 1'b0);

        // Reset in the middle of a stall with sel parked at 2.
        y_ready = 1'b0; load = 1'b1; s_in = 2'd2;
        tick();
        load = 1'b0;
        chk_out("stall_pre_rst", 8'h11, 2'd0, 1'b1, 1'b0);
        chk("stall_sel", 32'(dut.sel_q), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("mid_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("mid_rst_sel", 32'(dut.sel_q), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));

        sb_on = 1'b0;
        chk("sb_leftover", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
